// File: rtl/led_pattern_counter.sv
// Prescaled LED pattern generator: binary/Gray up-down count, bouncing scanner, LFSR.
// Define LED_PATTERN_LFSR_EN to build the LFSR for mode 11; otherwise mode 11 behaves as binary.
module led_pattern_counter #(
  parameter int EXT_CLOCK_FREQ = 50_000_000,
  parameter int TICK_HZ        = 5,
  parameter int LEDG_SIZE      = 8
) (
  input  logic                 EXTCLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [1:0]           MODE,
  input  logic                 DIR,
  input  logic                 STEP,
  output logic [LEDG_SIZE-1:0] LEDG,
  output logic                 TICK
);

  localparam int DIV = EXT_CLOCK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W   = LEDG_SIZE - 1;
  localparam int SW  = $clog2(LEDG_SIZE);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_SCAN = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("led_pattern_counter: EXT_CLOCK_FREQ / TICK_HZ must be at least 2");
    end
    if (LEDG_SIZE != 4 && LEDG_SIZE != 8 && LEDG_SIZE != 16) begin : g_bad_size
      $error("led_pattern_counter: LEDG_SIZE must be 4, 8 or 16");
    end
  endgenerate

`ifdef LED_PATTERN_LFSR_EN
  // Tap masks for x^4+x^3+1, x^8+x^6+x^5+x^4+1 and x^16+x^15+x^13+x^4+1.
  localparam logic [LEDG_SIZE-1:0] TAPS = LEDG_SIZE'((LEDG_SIZE == 4) ? 16'h000C :
                                                     (LEDG_SIZE == 8) ? 16'h00B8 : 16'hD008);
`endif

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef LED_PATTERN_LFSR_EN
    return m;
`else
    return (m == MODE_LFSR) ? MODE_BIN : m;
`endif
  endfunction

  function automatic logic [LEDG_SIZE-1:0] init_led(input logic [1:0] m);
    logic [1:0] e;
    e = eff_mode(m);
    return (e == MODE_SCAN || e == MODE_LFSR) ? LEDG_SIZE'(1) : '0;
  endfunction

  logic [1:0]           mode_q, mode_n;
  logic [PW-1:0]        pcnt, pcnt_n;
  logic [W-1:0]         cnt, cnt_n;
  logic                 ovf, ovf_n;
  logic [SW-1:0]        pos, pos_n;
  logic                 sdir, sdir_n;
  logic                 tmr, tick_n;
  logic [LEDG_SIZE-1:0] led_n;
`ifdef LED_PATTERN_LFSR_EN
  logic [LEDG_SIZE-1:0] lfsr, lfsr_n;
`endif

  always_comb begin
    mode_n = mode_q;
    pcnt_n = pcnt;
    cnt_n  = cnt;
    ovf_n  = ovf;
    pos_n  = pos;
    sdir_n = sdir;
`ifdef LED_PATTERN_LFSR_EN
    lfsr_n = lfsr;
`endif
    tick_n = 1'b0;
    led_n  = '0;
    tmr    = EN && (pcnt == PMAX);

    if (MODE != mode_q) begin
      // A mode switch swallows any advance in the same cycle and restarts the period.
      mode_n = MODE;
      pcnt_n = '0;
      cnt_n  = '0;
      ovf_n  = 1'b0;
      pos_n  = '0;
      sdir_n = 1'b0;
`ifdef LED_PATTERN_LFSR_EN
      lfsr_n = LEDG_SIZE'(1);
`endif
    end else begin
      if (EN) pcnt_n = tmr ? '0 : pcnt + PW'(1);
      if (tmr || STEP) begin
        tick_n = 1'b1;
        case (eff_mode(mode_q))
          MODE_SCAN: begin
            if (!sdir) begin
              if (pos == SW'(LEDG_SIZE - 1)) begin
                sdir_n = 1'b1;
                pos_n  = pos - SW'(1);
              end else begin
                pos_n  = pos + SW'(1);
              end
            end else begin
              if (pos == '0) begin
                sdir_n = 1'b0;
                pos_n  = SW'(1);
              end else begin
                pos_n  = pos - SW'(1);
              end
            end
          end
`ifdef LED_PATTERN_LFSR_EN
          MODE_LFSR: lfsr_n = {lfsr[LEDG_SIZE-2:0], ^(lfsr & TAPS)};
`endif
          default: begin
            if (DIR) begin
              ovf_n = ovf | (cnt == '0);
              cnt_n = cnt - W'(1);
            end else begin
              ovf_n = ovf | (&cnt);
              cnt_n = cnt + W'(1);
            end
          end
        endcase
      end
    end

    case (eff_mode(mode_n))
      MODE_GRAY: led_n = {ovf_n, cnt_n ^ (cnt_n >> 1)};
      MODE_SCAN: led_n = LEDG_SIZE'(1) << pos_n;
`ifdef LED_PATTERN_LFSR_EN
      MODE_LFSR: led_n = lfsr_n;
`endif
      default:   led_n = {ovf_n, cnt_n};
    endcase
  end

  always_ff @(posedge EXTCLK) begin
    if (RST) begin
      mode_q <= MODE;
      pcnt   <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      pos    <= '0;
      sdir   <= 1'b0;
`ifdef LED_PATTERN_LFSR_EN
      lfsr   <= LEDG_SIZE'(1);
`endif
      LEDG   <= init_led(MODE);
      TICK   <= 1'b0;
    end else begin
      mode_q <= mode_n;
      pcnt   <= pcnt_n;
      cnt    <= cnt_n;
      ovf    <= ovf_n;
      pos    <= pos_n;
      sdir   <= sdir_n;
`ifdef LED_PATTERN_LFSR_EN
      lfsr   <= lfsr_n;
`endif
      LEDG   <= led_n;
      TICK   <= tick_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_counter.sv
// Bench for led_pattern_counter (DIV = 10, 8 LEDs): directed vectors plus a per-cycle reference model.
module tb_led_pattern_counter;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst, en, dir, step;
  logic [1:0] mode;
  logic [7:0] ledg;
  logic       tick;

  int total = 0;
  int bad   = 0;

  led_pattern_counter #(
    .EXT_CLOCK_FREQ(100),
    .TICK_HZ       (10),
    .LEDG_SIZE     (8)
  ) dut (
    .EXTCLK(clk),
    .RST   (rst),
    .EN    (en),
    .MODE  (mode),
    .DIR   (dir),
    .STEP  (step),
    .LEDG  (ledg),
    .TICK  (tick)
  );

  always #5 clk = ~clk;

  // Reference model: counter value, scanner step count and LFSR word as plain integers.
  logic       m_ok = 1'b0;
  logic [1:0] m_mode;
  int         m_phase, m_val, m_k, m_lfsr;
  logic       m_ovf, m_tmr;
  logic [7:0] e_led;
  logic       e_tick;

  function automatic logic [1:0] eff(input logic [1:0] m);
`ifdef LED_PATTERN_LFSR_EN
    return m;
`else
    return (m == 2'b11) ? 2'b00 : m;
`endif
  endfunction

  function automatic logic [7:0] render();
    int p, g;
    case (eff(m_mode))
      2'b00: return {m_ovf, m_val[6:0]};
      2'b01: begin
        g = m_val ^ (m_val >> 1);
        return {m_ovf, g[6:0]};
      end
      2'b10: begin
        p = m_k % 14;
        if (p > 7) p = 14 - p;
        return 8'(1 << p);
      end
      default: return m_lfsr[7:0];
    endcase
  endfunction

  task automatic m_init();
    m_phase = 0;
    m_val   = 0;
    m_ovf   = 1'b0;
    m_k     = 0;
    m_lfsr  = 1;
  endtask

  task automatic m_adv();
    int fb;
    case (eff(m_mode))
      2'b10: m_k = m_k + 1;
      2'b11: begin
        fb     = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
      end
      default: begin
        if (dir) begin
          if (m_val == 0) begin m_val = 127; m_ovf = 1'b1; end
          else m_val = m_val - 1;
        end else begin
          if (m_val == 127) begin m_val = 0; m_ovf = 1'b1; end
          else m_val = m_val + 1;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ok   = 1'b1;
      m_mode = mode;
      m_init();
      e_tick = 1'b0;
    end else if (m_ok && mode != m_mode) begin
      m_mode = mode;
      m_init();
      e_tick = 1'b0;
    end else if (m_ok) begin
      m_tmr = en && (m_phase == DIV - 1);
      if (en) m_phase = (m_phase + 1) % DIV;
      e_tick = m_tmr || step;
      if (e_tick) m_adv();
    end
    if (m_ok) e_led = render();
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance n cycles, comparing DUT against the model on each falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (m_ok) begin
        chk("ledg_vs_model", ledg, e_led);
        chk("tick_vs_model", {7'b0, tick}, {7'b0, e_tick});
      end
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] scan_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b0; step = 1'b0;
    cyc(2);
    chk("reset_ledg", ledg, 8'h00);
    chk("reset_tick", {7'b0, tick}, 8'h00);

    // Binary up with EN held from release
    en = 1'b1; rst = 1'b0;
    cyc(9);  chk("t1_before_first", ledg, 8'h00);
    cyc(1);  chk("t1_first", ledg, 8'h01); chk("t1_first_tick", {7'b0, tick}, 8'h01);
    cyc(1);  chk("t1_tick_drop", {7'b0, tick}, 8'h00);
    cyc(9);  chk("t1_second", ledg, 8'h02);
    cyc(10); chk("t1_third", ledg, 8'h03);

    // Up wrap sets the sticky overflow
    cyc(1240); chk("t2_127", ledg, 8'h7F);
    cyc(10);   chk("t2_128", ledg, 8'h80);
    cyc(10);   chk("t2_129", ledg, 8'h81);

    // Down from reset wraps immediately
    rst = 1'b1; dir = 1'b1;
    cyc(1); rst = 1'b0;
    cyc(10); chk("t2_down_first", ledg, 8'hFF);
    cyc(10); chk("t2_down_second", ledg, 8'hFE);

    // Pause keeps the partial period; STEP works while paused
    rst = 1'b1; dir = 1'b0; en = 1'b1;
    cyc(1); rst = 1'b0;
    cyc(5); en = 1'b0;
    cyc(20); chk("t3_paused", ledg, 8'h00);
    en = 1'b1;
    cyc(4); chk("t3_resume_early", ledg, 8'h00);
    cyc(1); chk("t3_resume_tick", ledg, 8'h01);
    cyc(2); en = 1'b0; step = 1'b1;
    cyc(1); step = 1'b0;
    chk("t3_step", ledg, 8'h02); chk("t3_step_tick", {7'b0, tick}, 8'h01);
    cyc(10); chk("t3_step_paused", ledg, 8'h02);
    en = 1'b1;
    cyc(7); chk("t3_after_step_early", ledg, 8'h02);
    cyc(1); chk("t3_after_step_tick", ledg, 8'h03);

    // Bouncing scanner
    rst = 1'b1; mode = 2'b10; en = 1'b0;
    cyc(1); rst = 1'b0;
    chk("t4_reset", ledg, 8'h01);
    for (int i = 0; i < 16; i++) begin
      step = 1'b1;
      cyc(1); step = 1'b0;
      chk("t4_scan", ledg, scan_exp[i]);
      cyc(1);
    end
    step = 1'b1;
    cyc(3); step = 1'b0;
    chk("t4_held_step", ledg, 8'h20);

    // Mode change mid-count, then Gray sequence and STEP coinciding with a tick
    rst = 1'b1; mode = 2'b00; dir = 1'b0; en = 1'b0;
    cyc(1); rst = 1'b0;
    repeat (5) begin
      step = 1'b1; cyc(1); step = 1'b0; cyc(1);
    end
    chk("t5_cnt5", ledg, 8'h05);
    mode = 2'b01; en = 1'b1;
    cyc(1);  chk("t5_switch", ledg, 8'h00); chk("t5_switch_tick", {7'b0, tick}, 8'h00);
    cyc(9);  chk("t5_hold", ledg, 8'h00);
    cyc(1);  chk("t5_g1", ledg, 8'h01);
    cyc(10); chk("t5_g2", ledg, 8'h03);
    cyc(10); chk("t5_g3", ledg, 8'h02);
    cyc(9);  step = 1'b1;
    cyc(1);  step = 1'b0;
    chk("t5_step_and_tick", ledg, 8'h06); chk("t5_coincide_tick", {7'b0, tick}, 8'h01);
    cyc(1);  chk("t5_single", ledg, 8'h06); chk("t5_tick_low", {7'b0, tick}, 8'h00);

    // Direction change without reset, then mode 00 -> 11
    mode = 2'b00; en = 1'b0;
    cyc(1); chk("t6_to_bin", ledg, 8'h00);
    step = 1'b1; cyc(2); step = 1'b0;
    chk("t6_two_steps", ledg, 8'h02);
    dir = 1'b1; step = 1'b1; cyc(1); step = 1'b0;
    chk("t6_dir_down", ledg, 8'h01);
    dir = 1'b0; mode = 2'b11;
    cyc(1);
`ifdef LED_PATTERN_LFSR_EN
    chk("t6_lfsr_init", ledg, 8'h01);
    for (int i = 1; i <= 255; i++) begin
      step = 1'b1; cyc(1);
      chk("t6_lfsr_nonzero", {7'b0, ledg == 8'h00}, 8'h00);
      if (i == 1) chk("t6_lfsr_first", ledg, 8'h02);
      if (i < 255) chk("t6_lfsr_not_early", {7'b0, ledg == 8'h01}, 8'h00);
    end
    step = 1'b0;
    chk("t6_lfsr_period", ledg, 8'h01);
`else
    chk("t6_m11_init", ledg, 8'h00);
    step = 1'b1; cyc(1); step = 1'b0;
    chk("t6_m11_first", ledg, 8'h01);
    step = 1'b1; cyc(1); step = 1'b0;
    chk("t6_m11_second", ledg, 8'h02);
`endif
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
